// File: rtl/msi_cache_ctrl_p.sv
// Direct-mapped write-back MSI data-cache controller with bus snooping.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
module msi_cache_ctrl_p #(
    parameter int ADDR_W     = 13,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    localparam int OFS_W  = $clog2(LINE_WORDS),
    localparam int IDX_W  = $clog2(SETS),
    localparam int TAG_W  = ADDR_W - OFS_W - IDX_W,
    localparam int LINE_W = WORD_W * LINE_WORDS,
    localparam int LA_W   = ADDR_W - OFS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [WORD_W-1:0] cpu_wr_data,
    output logic [WORD_W-1:0] cpu_rd_data,
    output logic              d_rdy,
    output logic              bus_req,
    input  logic              grant,
    output logic [1:0]        bus_cmd,
    output logic [LA_W-1:0]   bus_addr,
    input  logic              snp_valid,
    input  logic [1:0]        snp_cmd,
    input  logic [LA_W-1:0]   snp_addr,
    output logic              snp_flush,
    output logic [LINE_W-1:0] snp_line,
    input  logic              peer_flush,
    input  logic [LINE_W-1:0] peer_line,
    output logic              u_re,
    output logic              u_we,
    output logic [LA_W-1:0]   u_addr,
    output logic [LINE_W-1:0] u_wr_data,
    input  logic              u_rdy,
    input  logic [LINE_W-1:0] u_rd_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       evict_cnt
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EVICT   = 3'd1;
    localparam logic [2:0] ST_BUSREQ  = 3'd2;
    localparam logic [2:0] ST_FILL    = 3'd3;
    localparam logic [2:0] ST_UPGRADE = 3'd4;

    localparam logic [1:0] LS_I = 2'd0;
    localparam logic [1:0] LS_S = 2'd1;
    localparam logic [1:0] LS_M = 2'd2;

    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_BUSRD   = 2'd1;
    localparam logic [1:0] CMD_BUSRDX  = 2'd2;
    localparam logic [1:0] CMD_BUSUPGR = 2'd3;

    logic [1:0]        st_arr   [SETS];
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [LINE_W-1:0] data_arr [SETS];

    logic [2:0]        state;
    logic [2:0]        state_nxt;

    logic [OFS_W-1:0]  ofs;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [LA_W-1:0]   la;
    logic [1:0]        line_st;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              hit;

    logic [IDX_W-1:0]  s_idx;
    logic [TAG_W-1:0]  s_tag;
    logic [1:0]        s_st;
    logic              s_hit;
    logic              s_to_s;
    logic              s_to_i;
    logic              conflict;

    logic              fill_done;
    logic              evict_done;
    logic              upg_lost;
    logic              upg_ok;
    logic              wr_hit;
    logic [LINE_W-1:0] fill_line;

    assign ofs       = cpu_addr[OFS_W-1:0];
    assign idx       = cpu_addr[OFS_W+IDX_W-1:OFS_W];
    assign tag       = cpu_addr[ADDR_W-1:OFS_W+IDX_W];
    assign la        = cpu_addr[ADDR_W-1:OFS_W];
    assign line_st   = st_arr[idx];
    assign line_tag  = tag_arr[idx];
    assign line_data = data_arr[idx];
    assign hit       = (line_st != LS_I) && (line_tag == tag);

    // Gated by hit so an invalid (never-written) line reads as zero.
    assign cpu_rd_data = hit ? line_data[ofs*WORD_W +: WORD_W] : '0;

    assign s_idx  = snp_addr[IDX_W-1:0];
    assign s_tag  = snp_addr[LA_W-1:IDX_W];
    assign s_st   = st_arr[s_idx];
    assign s_hit  = snp_valid && (s_st != LS_I) && (tag_arr[s_idx] == s_tag);
    assign s_to_s = s_hit && (s_st == LS_M) && (snp_cmd == CMD_BUSRD);
    assign s_to_i = s_hit && (((s_st == LS_M) && (snp_cmd == CMD_BUSRDX)) ||
                              ((s_st == LS_S) && ((snp_cmd == CMD_BUSRDX) ||
                                                  (snp_cmd == CMD_BUSUPGR))));
    assign snp_flush = s_hit && (s_st == LS_M) &&
                       ((snp_cmd == CMD_BUSRD) || (snp_cmd == CMD_BUSRDX));
    assign snp_line  = snp_flush ? data_arr[s_idx] : '0;

    // A snoop state change on the CPU's set takes precedence over a CPU write.
    assign conflict   = (s_to_s || s_to_i) && (s_idx == idx);
    assign fill_done  = (state == ST_FILL) && (u_rdy || peer_flush);
    assign evict_done = (state == ST_EVICT) && u_rdy;
    assign upg_lost   = !hit || conflict;
    assign fill_line  = peer_flush ? peer_line : u_rd_data;

    always_comb begin
        state_nxt = state;
        d_rdy     = 1'b0;
        bus_req   = 1'b0;
        bus_cmd   = CMD_NONE;
        bus_addr  = '0;
        u_re      = 1'b0;
        u_we      = 1'b0;
        u_addr    = '0;
        u_wr_data = '0;
        wr_hit    = 1'b0;
        upg_ok    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_we) begin
                    if (hit && (line_st == LS_M)) begin
                        d_rdy  = !conflict;
                        wr_hit = !conflict;
                    end else if (hit) begin
                        if (!conflict)
                            state_nxt = ST_UPGRADE;
                    end else begin
                        state_nxt = (line_st == LS_M) ? ST_EVICT : ST_BUSREQ;
                    end
                end else if (cpu_re) begin
                    if (hit)
                        d_rdy = 1'b1;
                    else
                        state_nxt = (line_st == LS_M) ? ST_EVICT : ST_BUSREQ;
                end
            end
            ST_EVICT: begin
                u_we      = 1'b1;
                u_addr    = {line_tag, idx};
                u_wr_data = line_data;
                if (u_rdy)
                    state_nxt = ST_BUSREQ;
            end
            ST_BUSREQ: begin
                bus_req = 1'b1;
                if (grant) begin
                    bus_cmd   = cpu_we ? CMD_BUSRDX : CMD_BUSRD;
                    bus_addr  = la;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                u_re   = 1'b1;
                u_addr = la;
                if (fill_done)
                    state_nxt = ST_IDLE;
            end
            ST_UPGRADE: begin
                bus_req = 1'b1;
                if (grant) begin
                    bus_addr = la;
                    if (upg_lost) begin
                        bus_cmd   = CMD_BUSRDX;
                        state_nxt = ST_FILL;
                    end else begin
                        bus_cmd   = CMD_BUSUPGR;
                        upg_ok    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Later assignments override the snoop update: controller-side changes on
    // its own set (evict, upgrade, fill) are the more recent state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SETS; i++)
                st_arr[IDX_W'(i)] <= LS_I;
        end else begin
            if (s_to_s)
                st_arr[s_idx] <= LS_S;
            if (s_to_i)
                st_arr[s_idx] <= LS_I;
            if (evict_done)
                st_arr[idx] <= LS_I;
            if (upg_ok)
                st_arr[idx] <= LS_M;
            if (fill_done)
                st_arr[idx] <= cpu_we ? LS_M : LS_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                tag_arr[idx]  <= tag;
                data_arr[idx] <= fill_line;
            end else if (wr_hit) begin
                data_arr[idx][ofs*WORD_W +: WORD_W] <= cpu_wr_data;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            evict_cnt <= '0;
        end else begin
            if (d_rdy && (cpu_re || cpu_we) && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 16'd1;
            if ((state == ST_IDLE) &&
                ((state_nxt == ST_EVICT) || (state_nxt == ST_BUSREQ)) &&
                (miss_cnt != '1))
                miss_cnt <= miss_cnt + 16'd1;
            if (evict_done && (evict_cnt != '1))
                evict_cnt <= evict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_msi_cache_ctrl_p.sv
// Directed self-checking bench for msi_cache_ctrl_p (default geometry).
module tb_msi_cache_ctrl_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_re;
    logic [15:0] cpu_wr_data;
    logic [15:0] cpu_rd_data;
    logic        d_rdy;
    logic        bus_req;
    logic        grant;
    logic [1:0]  bus_cmd;
    logic [10:0] bus_addr;
    logic        snp_valid;
    logic [1:0]  snp_cmd;
    logic [10:0] snp_addr;
    logic        snp_flush;
    logic [63:0] snp_line;
    logic        peer_flush;
    logic [63:0] peer_line;
    logic        u_re;
    logic        u_we;
    logic [10:0] u_addr;
    logic [63:0] u_wr_data;
    logic        u_rdy;
    logic [63:0] u_rd_data;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] evict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msi_cache_ctrl_p #(
        .ADDR_W(13),
        .WORD_W(16),
        .LINE_WORDS(4),
        .SETS(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_addr(cpu_addr),
        .cpu_we(cpu_we),
        .cpu_re(cpu_re),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .d_rdy(d_rdy),
        .bus_req(bus_req),
        .grant(grant),
        .bus_cmd(bus_cmd),
        .bus_addr(bus_addr),
        .snp_valid(snp_valid),
        .snp_cmd(snp_cmd),
        .snp_addr(snp_addr),
        .snp_flush(snp_flush),
        .snp_line(snp_line),
        .peer_flush(peer_flush),
        .peer_line(peer_line),
        .u_re(u_re),
        .u_we(u_we),
        .u_addr(u_addr),
        .u_wr_data(u_wr_data),
        .u_rdy(u_rdy),
        .u_rd_data(u_rd_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt),
        .evict_cnt(evict_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_addr    = '0;
        cpu_we      = 1'b0;
        cpu_re      = 1'b0;
        cpu_wr_data = '0;
        grant       = 1'b0;
        snp_valid   = 1'b0;
        snp_cmd     = 2'd0;
        snp_addr    = '0;
        peer_flush  = 1'b0;
        peer_line   = '0;
        u_rdy       = 1'b0;
        u_rd_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // From IDLE with a pending miss (clean victim): bus grant then memory fill.
    task automatic do_fill(input logic [63:0] data);
        tick();
        grant = 1'b1;
        tick();
        grant = 1'b0;
        u_rdy = 1'b1;
        u_rd_data = data;
        tick();
        u_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if ({d_rdy, bus_req, bus_cmd, u_re, u_we, snp_flush} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {d_rdy, bus_req, bus_cmd, u_re, u_we, snp_flush});
        end
        checks++;
        if ({bus_addr, u_addr, cpu_rd_data, u_wr_data, snp_line} !== '0) begin
            errors++;
            $display("FAIL reset_data: got bus_addr=%h u_addr=%h rd=%h wr=%h snp=%h expected 0",
                     bus_addr, u_addr, cpu_rd_data, u_wr_data, snp_line);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        do_reset();
        cpu_addr = 13'h0041;
        cpu_re = 1'b1;
        settle();
        checks++;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL rd_miss_rdy: got %b expected 0", d_rdy); end
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_cmd !== 2'd0) begin
            errors++; $display("FAIL rd_busreq: got req=%b cmd=%0d expected req=1 cmd=0", bus_req, bus_cmd);
        end
        grant = 1'b1;
        settle();
        checks++;
        if (bus_cmd !== 2'd1 || bus_addr !== 11'h010) begin
            errors++; $display("FAIL rd_grant: got cmd=%0d addr=%h expected cmd=1 addr=010", bus_cmd, bus_addr);
        end
        tick();
        grant = 1'b0;
        settle();
        checks++;
        if (u_re !== 1'b1 || u_addr !== 11'h010 || bus_cmd !== 2'd0) begin
            errors++; $display("FAIL rd_fill: got u_re=%b u_addr=%h cmd=%0d expected 1 010 0", u_re, u_addr, bus_cmd);
        end
        u_rdy = 1'b1;
        u_rd_data = 64'h4444_3333_2222_1111;
        tick();
        u_rdy = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1 || cpu_rd_data !== 16'h2222) begin
            errors++; $display("FAIL rd_done: got rdy=%b data=%h expected 1 2222", d_rdy, cpu_rd_data);
        end
        cpu_re = 1'b0;
    endtask

    task automatic test_write_miss_evict();
        do_reset();
        cpu_addr = 13'h0041;
        cpu_we = 1'b1;
        cpu_wr_data = 16'hBEEF;
        tick();
        grant = 1'b1;
        settle();
        checks++;
        if (bus_cmd !== 2'd2) begin errors++; $display("FAIL wr_busrdx: got %0d expected 2", bus_cmd); end
        tick();
        grant = 1'b0;
        u_rdy = 1'b1;
        u_rd_data = 64'h4444_3333_2222_1111;
        tick();
        u_rdy = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1) begin errors++; $display("FAIL wr_done: got %b expected 1", d_rdy); end
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b1;
        settle();
        checks++;
        if (d_rdy !== 1'b1 || cpu_rd_data !== 16'hBEEF) begin
            errors++; $display("FAIL wr_readback: got rdy=%b data=%h expected 1 beef", d_rdy, cpu_rd_data);
        end
        cpu_addr = 13'h0441;
        settle();
        checks++;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL ev_miss: got %b expected 0", d_rdy); end
        tick();
        checks++;
        if (u_we !== 1'b1 || u_addr !== 11'h010 || u_wr_data !== 64'h4444_3333_BEEF_1111) begin
            errors++; $display("FAIL ev_wb: got we=%b addr=%h data=%h expected 1 010 44443333beef1111",
                               u_we, u_addr, u_wr_data);
        end
        tick();
        checks++;
        if (u_we !== 1'b1 || bus_req !== 1'b0) begin
            errors++; $display("FAIL ev_hold: got we=%b req=%b expected 1 0", u_we, bus_req);
        end
        u_rdy = 1'b1;
        tick();
        u_rdy = 1'b0;
        settle();
        checks++;
        if (u_we !== 1'b0 || bus_req !== 1'b1) begin
            errors++; $display("FAIL ev_to_busreq: got we=%b req=%b expected 0 1", u_we, bus_req);
        end
        grant = 1'b1;
        settle();
        checks++;
        if (bus_cmd !== 2'd1 || bus_addr !== 11'h110) begin
            errors++; $display("FAIL ev_grant: got cmd=%0d addr=%h expected 1 110", bus_cmd, bus_addr);
        end
        tick();
        grant = 1'b0;
        u_rdy = 1'b1;
        u_rd_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        u_rdy = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1 || cpu_rd_data !== 16'hCCCC) begin
            errors++; $display("FAIL ev_done: got rdy=%b data=%h expected 1 cccc", d_rdy, cpu_rd_data);
        end
        cpu_re = 1'b0;
    endtask

    task automatic test_upgrade();
        do_reset();
        cpu_addr = 13'h0041;
        cpu_re = 1'b1;
        do_fill(64'h4444_3333_2222_1111);
        cpu_re = 1'b0;
        cpu_addr = 13'h0040;
        cpu_we = 1'b1;
        cpu_wr_data = 16'h1234;
        settle();
        checks++;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL up_wr_s: got %b expected 0", d_rdy); end
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_cmd !== 2'd0) begin
            errors++; $display("FAIL up_req: got req=%b cmd=%0d expected 1 0", bus_req, bus_cmd);
        end
        grant = 1'b1;
        settle();
        checks++;
        if (bus_cmd !== 2'd3 || bus_addr !== 11'h010) begin
            errors++; $display("FAIL up_grant: got cmd=%0d addr=%h expected 3 010", bus_cmd, bus_addr);
        end
        tick();
        grant = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1) begin errors++; $display("FAIL up_done: got %b expected 1", d_rdy); end
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic test_snoop_busrd();
        snp_valid = 1'b1;
        snp_cmd = 2'd1;
        snp_addr = 11'h010;
        settle();
        checks++;
        if (snp_flush !== 1'b1 || snp_line !== 64'h4444_3333_2222_1234) begin
            errors++; $display("FAIL snp_rd_flush: got flush=%b line=%h expected 1 4444333322221234", snp_flush, snp_line);
        end
        tick();
        checks++;
        if (snp_flush !== 1'b0) begin errors++; $display("FAIL snp_rd_now_s: got %b expected 0", snp_flush); end
        snp_valid = 1'b0;
        cpu_addr = 13'h0041;
        cpu_we = 1'b1;
        cpu_wr_data = 16'h5555;
        settle();
        checks++;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL snp_rd_wr_s: got %b expected 0", d_rdy); end
        tick();
        checks++;
        if (bus_req !== 1'b1) begin errors++; $display("FAIL snp_rd_upg: got %b expected 1", bus_req); end
    endtask

    task automatic test_upgrade_lost();
        snp_valid = 1'b1;
        snp_cmd = 2'd2;
        snp_addr = 11'h010;
        settle();
        checks++;
        if (snp_flush !== 1'b0) begin errors++; $display("FAIL lost_noflush: got %b expected 0", snp_flush); end
        tick();
        snp_valid = 1'b0;
        grant = 1'b1;
        settle();
        checks++;
        if (bus_cmd !== 2'd2 || bus_addr !== 11'h010) begin
            errors++; $display("FAIL lost_busrdx: got cmd=%0d addr=%h expected 2 010", bus_cmd, bus_addr);
        end
        tick();
        grant = 1'b0;
        checks++;
        if (u_re !== 1'b1) begin errors++; $display("FAIL lost_fill: got %b expected 1", u_re); end
        peer_flush = 1'b1;
        peer_line = 64'h9999_8888_7777_6666;
        tick();
        peer_flush = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1 || cpu_rd_data !== 16'h7777) begin
            errors++; $display("FAIL lost_done: got rdy=%b data=%h expected 1 7777", d_rdy, cpu_rd_data);
        end
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b1;
        settle();
        checks++;
        if (cpu_rd_data !== 16'h5555) begin errors++; $display("FAIL lost_word1: got %h expected 5555", cpu_rd_data); end
        cpu_addr = 13'h0043;
        settle();
        checks++;
        if (cpu_rd_data !== 16'h9999) begin errors++; $display("FAIL lost_word3: got %h expected 9999", cpu_rd_data); end
        cpu_re = 1'b0;
    endtask

    task automatic test_snoop_conflict();
        cpu_addr = 13'h0042;
        cpu_we = 1'b1;
        cpu_wr_data = 16'hABCD;
        snp_valid = 1'b1;
        snp_cmd = 2'd2;
        snp_addr = 11'h010;
        settle();
        checks++;
        if (d_rdy !== 1'b0 || snp_flush !== 1'b1 || snp_line !== 64'h9999_8888_5555_6666) begin
            errors++; $display("FAIL conf_same_cycle: got rdy=%b flush=%b line=%h expected 0 1 9999888855556666",
                               d_rdy, snp_flush, snp_line);
        end
        tick();
        snp_valid = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL conf_retry: got rdy=%b req=%b expected 0 0", d_rdy, bus_req);
        end
        tick();
        checks++;
        if (bus_req !== 1'b1) begin errors++; $display("FAIL conf_busreq: got %b expected 1", bus_req); end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        u_rdy = 1'b1;
        u_rd_data = 64'h0;
        tick();
        u_rdy = 1'b0;
        settle();
        checks++;
        if (d_rdy !== 1'b1) begin errors++; $display("FAIL conf_done: got %b expected 1", d_rdy); end
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cpu_addr = 13'h0041;
        cpu_we = 1'b1;
        cpu_wr_data = 16'h0007;
        do_fill(64'h1);
        tick();
        cpu_we = 1'b0;
        cpu_addr = 13'h0441;
        cpu_re = 1'b1;
        tick();
        checks++;
        if (u_we !== 1'b1) begin errors++; $display("FAIL mid_evict: got %b expected 1", u_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (u_we !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL mid_abort: got we=%b req=%b expected 0 0", u_we, bus_req);
        end
        cpu_addr = 13'h0041;
        settle();
        checks++;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL mid_invalid: got %b expected 0", d_rdy); end
        cpu_re = 1'b0;
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        cpu_addr = 13'h0041;
        cpu_we = 1'b1;
        cpu_wr_data = 16'h0001;
        do_fill(64'h0);
        tick();
        cpu_we = 1'b0;
        cpu_addr = 13'h0441;
        cpu_re = 1'b1;
        tick();
        u_rdy = 1'b1;
        tick();
        u_rdy = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        u_rdy = 1'b1;
        tick();
        u_rdy = 1'b0;
        tick();
        cpu_addr = 13'h0841;
        do_fill(64'h0);
        tick();
        cpu_re = 1'b0;
        settle();
        checks++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd3 || evict_cnt !== 16'd1) begin
            errors++; $display("FAIL stats_seq: got hit=%0d miss=%0d evict=%0d expected 3 3 1",
                               hit_cnt, miss_cnt, evict_cnt);
        end
        cpu_re = 1'b1;
        repeat (70000) tick();
        cpu_re = 1'b0;
        settle();
        checks++;
        if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd3) begin
            errors++; $display("FAIL stats_sat: got hit=%h miss=%0d expected ffff 3", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_miss();
        test_write_miss_evict();
        test_upgrade();
        test_snoop_busrd();
        test_upgrade_lost();
        test_snoop_conflict();
        test_reset_mid();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
